// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester and SRAM bus bundle for sram_arbiter
interface sram_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              Req_A;
    logic              Req_B;
    logic              RW_A;
    logic              RW_B;
    logic [ADDR_W-1:0] Addr_A;
    logic [ADDR_W-1:0] Addr_B;
    logic [DATA_W-1:0] Wdata_A;
    logic [DATA_W-1:0] Wdata_B;
    logic              Gnt_A;
    logic              Gnt_B;
    logic [DATA_W-1:0] Rdata_A;
    logic [DATA_W-1:0] Rdata_B;
    logic              Rvalid_A;
    logic              Rvalid_B;
    logic              Busy;
    logic              Mem_En;
    logic              Mem_RW;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Wdata;
    logic [DATA_W-1:0] Mem_Rdata;

    // Arbiter side
    modport slave (
        input  Req_A, Req_B, RW_A, RW_B, Addr_A, Addr_B, Wdata_A, Wdata_B, Mem_Rdata,
        output Gnt_A, Gnt_B, Rdata_A, Rdata_B, Rvalid_A, Rvalid_B, Busy,
               Mem_En, Mem_RW, Mem_Addr, Mem_Wdata
    );

    // Requesters and SRAM side
    modport master (
        output Req_A, Req_B, RW_A, RW_B, Addr_A, Addr_B, Wdata_A, Wdata_B, Mem_Rdata,
        input  Gnt_A, Gnt_B, Rdata_A, Rdata_B, Rvalid_A, Rvalid_B, Busy,
               Mem_En, Mem_RW, Mem_Addr, Mem_Wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester round-robin SRAM arbiter/sequencer (optional clear: SRAM_ARB_CLEAR_EN)
module sram_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic Clk,
    input  logic Rst_n,
`ifdef SRAM_ARB_CLEAR_EN
    input  logic Clr_Req,
    output logic Clr_Done,
`endif
    sram_arbiter_if.slave bus
);

`ifdef SRAM_ARB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, ACCESS, RDCAP, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RDCAP} state_t;
`endif

    state_t            state_q, state_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              last_b_q, last_b_d;   // 1: B was granted last
    logic              owner_b_q, owner_b_d; // 1: B owns the access in flight
    logic              win_b;
`ifdef SRAM_ARB_CLEAR_EN
    logic              clr_done_q, clr_done_d;
`endif

    // Next-state, arbitration and sequencing
    always_comb begin
        state_d     = state_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        rvalid_a_d  = 1'b0;
        rvalid_b_d  = 1'b0;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        last_b_d    = last_b_q;
        owner_b_d   = owner_b_q;
        win_b       = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
        clr_done_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
                if (Clr_Req) begin
                    mem_en_d    = 1'b1;
                    mem_rw_d    = 1'b1;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    state_d     = CLEAR;
                end else
`endif
                if (bus.Req_A || bus.Req_B) begin
                    // On a tie the requester not granted last wins
                    win_b       = bus.Req_B && (!bus.Req_A || !last_b_q);
                    last_b_d    = win_b;
                    owner_b_d   = win_b;
                    gnt_a_d     = !win_b;
                    gnt_b_d     = win_b;
                    mem_en_d    = 1'b1;
                    mem_rw_d    = win_b ? bus.RW_B    : bus.RW_A;
                    mem_addr_d  = win_b ? bus.Addr_B  : bus.Addr_A;
                    mem_wdata_d = win_b ? bus.Wdata_B : bus.Wdata_A;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                mem_en_d = 1'b0;
                state_d  = mem_rw_q ? IDLE : RDCAP;
            end
            RDCAP: begin
                if (owner_b_q) begin
                    rdata_b_d  = bus.Mem_Rdata;
                    rvalid_b_d = 1'b1;
                end else begin
                    rdata_a_d  = bus.Mem_Rdata;
                    rvalid_a_d = 1'b1;
                end
                state_d = IDLE;
            end
`ifdef SRAM_ARB_CLEAR_EN
            CLEAR: begin
                if (mem_addr_q == {ADDR_W{1'b1}}) begin
                    mem_en_d   = 1'b0;
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
`endif
            default: begin
                mem_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            last_b_q    <= 1'b1;
            owner_b_q   <= 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
            clr_done_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            rvalid_a_q  <= rvalid_a_d;
            rvalid_b_q  <= rvalid_b_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            last_b_q    <= last_b_d;
            owner_b_q   <= owner_b_d;
`ifdef SRAM_ARB_CLEAR_EN
            clr_done_q  <= clr_done_d;
`endif
        end
    end

    assign bus.Gnt_A     = gnt_a_q;
    assign bus.Gnt_B     = gnt_b_q;
    assign bus.Rvalid_A  = rvalid_a_q;
    assign bus.Rvalid_B  = rvalid_b_q;
    assign bus.Rdata_A   = rdata_a_q;
    assign bus.Rdata_B   = rdata_b_q;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Mem_En    = mem_en_q;
    assign bus.Mem_RW    = mem_rw_q;
    assign bus.Mem_Addr  = mem_addr_q;
    assign bus.Mem_Wdata = mem_wdata_q;
`ifdef SRAM_ARB_CLEAR_EN
    assign Clr_Done      = clr_done_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
    logic Clr_Req = 1'b0;
    logic Clr_Done;
`endif

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
`ifdef SRAM_ARB_CLEAR_EN
        .Clr_Req (Clr_Req),
        .Clr_Done(Clr_Done),
`endif
        .bus     (bus.slave)
    );

    always #5 Clk = ~Clk;

    // SRAM model: registered Data_Out, zero in every cycle without a read
    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] exp_mem [0:(1<<ADDR_W)-1];
    always @(posedge Clk) begin
        if (bus.Mem_En && bus.Mem_RW) sram[bus.Mem_Addr] <= bus.Mem_Wdata;
        if (bus.Mem_En && !bus.Mem_RW) bus.Mem_Rdata <= sram[bus.Mem_Addr];
        else bus.Mem_Rdata <= '0;
    end

    int tests = 0;
    int fails = 0;
    int en_cycles = 0;

    typedef struct {
        logic              who;   // 0 = A, 1 = B
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic              who;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Output monitor: read returns are popped from the scoreboard
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (bus.Mem_En) en_cycles++;
            if (bus.Gnt_A && bus.Gnt_B) check("gnt_overlap", 1, 0);
            if (bus.Rvalid_A && bus.Rvalid_B) begin
                check("rvalid_overlap", 1, 0);
            end else if (bus.Rvalid_A || bus.Rvalid_B) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rvalid_owner", {31'b0, bus.Rvalid_B}, {31'b0, e.who});
                    check("rdata", e.who ? bus.Rdata_B : bus.Rdata_A, e.data);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!bus.Busy) return;
            @(posedge Clk); #1;
        end
        check("idle_timeout", 1, 0);
    endtask

    // One access: raise Req, wait for the grant, check latency and Mem_En width
    task automatic do_access(input logic who, input logic rw, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata);
        int en0;
        bit got;
        en0 = en_cycles;
        got = 0;
        if (who) begin bus.Req_B = 1; bus.RW_B = rw; bus.Addr_B = addr; bus.Wdata_B = wdata; end
        else     begin bus.Req_A = 1; bus.RW_A = rw; bus.Addr_A = addr; bus.Wdata_A = wdata; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge Clk); #1;
            got = who ? bus.Gnt_B : bus.Gnt_A;
        end
        bus.Req_A = 0;
        bus.Req_B = 0;
        if (!got) begin
            check("grant_timeout", 1, 0);
            return;
        end
        if (rw) exp_mem[addr] = wdata;
        else sb.push_back('{who, exp_rdata});
        @(posedge Clk); #1;
        if (rw) begin
            check("write_landed", sram[addr], wdata);
            check("write_idle_edge1", {31'b0, bus.Busy}, 0);
        end else begin
            check("rvalid_early", {31'b0, bus.Rvalid_A | bus.Rvalid_B}, 0);
            @(posedge Clk); #1;
            check("rvalid_edge2", {31'b0, who ? bus.Rvalid_B : bus.Rvalid_A}, 1);
        end
        wait_idle();
        check("mem_en_cycles", en_cycles - en0, 1);
    endtask

    vec_t vecs[7];
    int   gcyc[4];
    logic order[3];
    int   ng;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            sram[i]    = 32'hA5A5_0000 + i;
            exp_mem[i] = 32'hA5A5_0000 + i;
        end
        bus.Req_A = 0; bus.Req_B = 0; bus.RW_A = 0; bus.RW_B = 0;
        bus.Addr_A = '0; bus.Addr_B = '0; bus.Wdata_A = '0; bus.Wdata_B = '0;
        bus.Mem_Rdata = '0;

        vecs[0] = '{1'b0, 1'b1, 7'd5,   32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 7'd5,   32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 7'd127, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 7'd127, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 7'd5,   32'h0,        32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 7'd0,   32'h00000001, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 7'd0,   32'h0,        32'h00000001};

        // Reset values
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy",   {31'b0, bus.Busy}, 0);
        check("rst_mem_en", {31'b0, bus.Mem_En}, 0);
        check("rst_gnt",    {30'b0, bus.Gnt_A, bus.Gnt_B}, 0);
        check("rst_rdata_a", bus.Rdata_A, 0);
        check("rst_mem_addr", {25'b0, bus.Mem_Addr}, 0);
        check("rst_mem_wdata", bus.Mem_Wdata, 0);
        Rst_n = 1;
        @(posedge Clk); #1;

        // Table-driven accesses
        foreach (vecs[i]) begin
            do_access(vecs[i].who, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
            if (i == 1) check("rdata_b_quiet", bus.Rdata_B, 0);
        end

        // Reset during RDCAP of an A read
        bus.Req_A = 1; bus.RW_A = 0; bus.Addr_A = 7'd5;
        ng = 0;
        for (int i = 0; i < 20 && ng == 0; i++) begin
            @(posedge Clk); #1;
            if (bus.Gnt_A) ng = 1;
        end
        bus.Req_A = 0;
        check("midrd_grant", ng, 1);
        @(posedge Clk); #2;
        Rst_n = 0;
        #1;
        check("midrd_rdata_a", bus.Rdata_A, 0);
        check("midrd_busy",    {31'b0, bus.Busy}, 0);
        check("midrd_rvalid",  {30'b0, bus.Rvalid_A, bus.Rvalid_B}, 0);
        repeat (2) @(posedge Clk);
        #3;
        Rst_n = 1;
        @(posedge Clk); #1;
        check("midrd_no_rvalid", {30'b0, bus.Rvalid_A, bus.Rvalid_B}, 0);

        // Tie with held requests: A, B, A
        bus.Req_A = 1; bus.RW_A = 0; bus.Addr_A = 7'd5;
        bus.Req_B = 1; bus.RW_B = 0; bus.Addr_B = 7'd127;
        ng = 0;
        for (int i = 0; i < 40 && ng < 3; i++) begin
            @(posedge Clk); #1;
            if (bus.Gnt_A) begin order[ng] = 0; ng++; sb.push_back('{1'b0, exp_mem[5]}); end
            else if (bus.Gnt_B) begin order[ng] = 1; ng++; sb.push_back('{1'b1, exp_mem[127]}); end
        end
        bus.Req_A = 0; bus.Req_B = 0;
        check("tie_grants", ng, 3);
        if (ng == 3) check("tie_order", {29'b0, order[0], order[1], order[2]}, 32'b010);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        wait_idle();

        // Back-to-back writes from A
        bus.Req_A = 1; bus.RW_A = 1; bus.Addr_A = 7'd10; bus.Wdata_A = 32'hC0DE_0000;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(posedge Clk); #1;
            if (bus.Gnt_A) begin
                gcyc[ng] = c;
                exp_mem[bus.Addr_A] = bus.Wdata_A;
                ng++;
                bus.Addr_A  = 7'd10 + 7'(ng);
                bus.Wdata_A = 32'hC0DE_0000 + ng;
                if (ng == 4) bus.Req_A = 0;
            end
        end
        bus.Req_A = 0;
        check("b2b_grants", ng, 4);
        if (ng == 4)
            for (int i = 1; i < 4; i++) check("b2b_spacing", gcyc[i] - gcyc[i-1], 2);
        @(posedge Clk); #1;
        wait_idle();
        for (int i = 0; i < 4; i++) check("b2b_sram", sram[10+i], 32'hC0DE_0000 + i);

`ifdef SRAM_ARB_CLEAR_EN
        do_access(1'b0, 1'b1, 7'd0,   32'h1111_0000, 0);
        do_access(1'b1, 1'b1, 7'd64,  32'h2222_0000, 0);
        do_access(1'b0, 1'b1, 7'd127, 32'h3333_0000, 0);
        Clr_Req = 1;
        bus.Req_A = 1; bus.RW_A = 0; bus.Addr_A = 7'd64;
        @(posedge Clk); #1;
        Clr_Req = 0;
        check("clr_first_gnt", {31'b0, bus.Gnt_A}, 0);
        check("clr_first_en",  {30'b0, bus.Mem_En, bus.Mem_RW}, 32'b11);
        check("clr_first_addr", {25'b0, bus.Mem_Addr}, 0);
        check("clr_wdata", bus.Mem_Wdata, 0);
        ng = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge Clk); #1;
            if (Clr_Done) break;
            if (bus.Gnt_A) check("clr_gnt_during", 1, 0);
            if (bus.Mem_En) begin
                if (bus.Mem_Addr != 7'(ng)) check("clr_addr_seq", {25'b0, bus.Mem_Addr}, ng);
                ng++;
            end
        end
        check("clr_done", {31'b0, Clr_Done}, 1);
        check("clr_count", ng, 128);
        for (int i = 0; i < (1 << ADDR_W); i++) exp_mem[i] = '0;
        @(posedge Clk); #1;
        check("clr_then_gnt_a", {31'b0, bus.Gnt_A}, 1);
        bus.Req_A = 0;
        if (bus.Gnt_A) sb.push_back('{1'b0, 32'h0});
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        wait_idle();
        do_access(1'b0, 1'b0, 7'd0,   0, 32'h0);
        do_access(1'b1, 1'b0, 7'd127, 0, 32'h0);
`endif

        repeat (3) @(posedge Clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the team's 128x32 synchronous single-port SRAM.
  - The SRAM has En and RW (1 = write) inputs.
  - Its Data_Out is registered and is driven to 0 in every cycle without a read.
- The block serialises accesses from requester A and requester B and drives all SRAM control and data inputs from registers.
- It captures SRAM read data and returns it to the requester that issued the read, with a valid pulse.

Parameters:
- ADDR_W, 7, SRAM address width (depth = 2**ADDR_W).
- DATA_W, 32, SRAM data width.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Req_A / Req_B  in  1  access request; held high until the matching Gnt pulse.
- RW_A / RW_B  in  1  1 = write, 0 = read; sampled at the grant edge.
- Addr_A / Addr_B  in  ADDR_W  access address; sampled at the grant edge.
- Wdata_A / Wdata_B  in  DATA_W  write data; sampled at the grant edge.
- Gnt_A / Gnt_B  out  1  one-cycle pulse: request accepted.
- Rdata_A / Rdata_B  out  DATA_W  read data; holds its value until the next read by the same requester.
- Rvalid_A / Rvalid_B  out  1  one-cycle pulse: Rdata is valid.
- Busy  out  1  high in any state other than IDLE.
- Mem_En  out  1  to SRAM En.
- Mem_RW  out  1  to SRAM RW.
- Mem_Addr  out  ADDR_W  to SRAM Addr.
- Mem_Wdata  out  DATA_W  to SRAM Data_In.
- Mem_Rdata  in  DATA_W  from SRAM Data_Out.

Behaviour:
- Reset (Rst_n = 0, asynchronous):
  - State is IDLE.
  - All outputs are 0: Gnt, Rvalid, Rdata, Mem_En, Mem_RW, Mem_Addr, Mem_Wdata, Busy.
  - Last-granted pointer is B, so A wins the first tie.
  - SRAM contents are not touched.
  - Reset mid-access aborts the access. No Gnt or Rvalid is emitted afterwards. A partially issued write may or may not land.
- States:
  - IDLE: arbitrate.
  - ACCESS: SRAM enable cycle.
  - RDCAP: read-data capture.
  - CLEAR: only with the optional feature.
- IDLE, on a posedge with any Req high:
  - Select the winner.
    - Only one Req high: that requester wins.
    - Both high: the requester that is not the last-granted one wins. Update the pointer.
  - Register the winner's RW, Addr and Wdata onto Mem_RW, Mem_Addr and Mem_Wdata. Set Mem_En = 1.
  - Pulse the winner's Gnt for 1 cycle. Remember the winner as the owner. Go to ACCESS.
  - No Req high: stay in IDLE with Mem_En = 0.
- ACCESS (the SRAM samples En at the end of this cycle):
  - Next edge: Mem_En <= 0.
  - Write: go to IDLE.
  - Read: go to RDCAP.
- RDCAP:
  - Next edge: owner's Rdata <= Mem_Rdata. Pulse the owner's Rvalid for 1 cycle. Go to IDLE.
- Latency, counted from the grant edge (edge 0):
  - Write: committed in the SRAM at edge 1; IDLE again at edge 1. Back-to-back writes take 2 cycles each.
  - Read: Rvalid and Rdata at edge 2; a new grant is possible at edge 3. Back-to-back reads take 3 cycles each.
- Requests are not sampled outside IDLE. A request raised during ACCESS or RDCAP waits.
- Gnt_A and Gnt_B are never high together. Rvalid goes only to the owner.
- Mem_RW, Mem_Addr and Mem_Wdata hold their last values when Mem_En = 0.
- A requester that keeps Req high after Gnt is treated as a new request at the next IDLE. Round-robin still applies.
- Address wrap: not applicable. The full ADDR_W range is legal.

Optional Feature:
- Macro: SRAM_ARB_CLEAR_EN.
- When defined, the block adds these ports:
  - Clr_Req  in  1  request to clear the whole SRAM.
  - Clr_Done  out  1  one-cycle pulse when the clear completes.
- Clear behaviour:
  - In IDLE, Clr_Req has priority over Req_A and Req_B.
  - The block enters CLEAR with Mem_En = 1, Mem_RW = 1, Mem_Wdata = 0, Mem_Addr = 0.
  - Mem_Addr increments by 1 every cycle, holding each address for one cycle.
  - After the cycle with Mem_Addr = 2**ADDR_W - 1 (128 enable cycles in total), the block sets Mem_En <= 0, pulses Clr_Done and returns to IDLE.
  - Busy is high throughout. No Gnt is issued during CLEAR.
  - The round-robin pointer is unchanged.
  - Reset during CLEAR aborts the clear; no Clr_Done.
- When not defined: Clr_Req, Clr_Done and the CLEAR state do not exist. Behaviour is exactly as described above.

Test Plan:
- Write then read, requester A:
  - Stimulus: A writes 0xDEADBEEF to address 5, then A reads address 5.
  - Response: Gnt_A pulses for each access; Mem_En is high for exactly 1 cycle per access; Rvalid_A pulses 2 edges after the read grant with Rdata_A = 0xDEADBEEF; Rdata_B stays 0.
- Tie after reset:
  - Stimulus: A and B both request reads at the same edge and hold their requests.
  - Response: grants go A, then B, then A; each Rvalid goes to the correct requester; Gnt_A and Gnt_B never overlap.
- Cross-requester data path:
  - Stimulus: B writes 0x12345678 to address 127; A then reads address 127.
  - Response: Rdata_A = 0x12345678; Rvalid_B stays 0 during A's read.
- Reset mid-read:
  - Stimulus: Rst_n goes low during RDCAP.
  - Response: outputs go to 0 immediately; no Rvalid pulse; after release, the first grant goes to A.
- Clear (with SRAM_ARB_CLEAR_EN defined):
  - Stimulus: fill addresses 0, 64 and 127; assert Clr_Req together with Req_A.
  - Response: CLEAR is entered first; 128 write cycles to addresses 0..127; Clr_Done pulses; then Gnt_A; reads of addresses 0, 64 and 127 return 0.
- Back-to-back throughput:
  - Stimulus: A holds Req_A high for 4 writes.
  - Response: Gnt_A pulses every 2 cycles; the SRAM holds all 4 values.
